// File: rtl/cnt_event_rebuilder.sv
// Rebuilds discrete valid/ready events from a wrapping, synchronized event count.
// Optional build macro CNT_EVT_STEP_CHK_EN flags and discards backward/aliased steps.
module cnt_event_rebuilder #(
  parameter int W  = 8,
  parameter int PW = 16,
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  cnt_in,
  input  logic          en,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [PW-1:0] pending,
  output logic [TW-1:0] total,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic          step_err
);

  // Sum is wide enough for any pending + delta, even when W exceeds PW.
  localparam int SW = ((W > PW) ? W : PW) + 2;
  localparam logic [SW-1:0] PEND_MAX = {{(SW-PW){1'b0}}, {PW{1'b1}}};

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  last_q, last_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [TW-1:0] total_q, total_d;
  logic          ovf_q, ovf_d;
  logic          step_err_q, step_err_d;
  logic          evt_valid_q, evt_valid_d;

  logic [W-1:0]  delta;
  logic [W-1:0]  add;
  logic [SW-1:0] sum;
  logic          take;
  logic          step_bad;
  logic          sat;

  always_comb begin
    delta    = cnt_in - last_q;
    step_bad = 1'b0;
`ifdef CNT_EVT_STEP_CHK_EN
    step_bad = (state_q == RUN) && delta[W-1];
`endif
    take = evt_valid_q & evt_ready;

    // The INIT edge only captures the count, so a post-reset value is never a burst.
    add = '0;
    if (state_q == RUN && en && !step_bad) begin
      add = delta;
    end

    sum = SW'(pending_q) + SW'(add) - SW'(take);
    sat = (sum > PEND_MAX);

    state_d     = RUN;
    last_d      = cnt_in;
    pending_d   = sat ? PEND_MAX[PW-1:0] : sum[PW-1:0];
    ovf_d       = sat | (ovf_q & ~ovf_clr);
    total_d     = total_q + TW'(take);
    evt_valid_d = (pending_d != '0);

`ifdef CNT_EVT_STEP_CHK_EN
    step_err_d = step_bad | (step_err_q & ~ovf_clr);
`else
    step_err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      last_q      <= '0;
      pending_q   <= '0;
      total_q     <= '0;
      ovf_q       <= 1'b0;
      step_err_q  <= 1'b0;
      evt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      pending_q   <= pending_d;
      total_q     <= total_d;
      ovf_q       <= ovf_d;
      step_err_q  <= step_err_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign pending   = pending_q;
  assign total     = total_q;
  assign ovf       = ovf_q;
  assign step_err  = step_err_q;

endmodule

// File: tb/tb_cnt_event_rebuilder.sv
// Directed bench for cnt_event_rebuilder; a PW=4 copy shares the stimulus for saturation checks.
module tb_cnt_event_rebuilder;

  logic        clk;
  logic        rst;
  logic [7:0]  cnt_in;
  logic        en;
  logic        evt_ready;
  logic        ovf_clr;

  logic        evt_valid;
  logic [15:0] pending;
  logic [31:0] total;
  logic        ovf;
  logic        step_err;

  logic        evt_valid_s;
  logic [3:0]  pending_s;
  logic [31:0] total_s;
  logic        ovf_s;
  logic        step_err_s;

  int testCount = 0;
  int failCount = 0;
  int validCycles;

  cnt_event_rebuilder #(.W(8), .PW(16), .TW(32)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .en(en),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .pending(pending), .total(total), .ovf(ovf),
    .ovf_clr(ovf_clr), .step_err(step_err)
  );

  cnt_event_rebuilder #(.W(8), .PW(4), .TW(32)) dut_small (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .en(en),
    .evt_valid(evt_valid_s), .evt_ready(evt_ready),
    .pending(pending_s), .total(total_s), .ovf(ovf_s),
    .ovf_clr(ovf_clr), .step_err(step_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change #1 after a rising edge so they are stable at the next one.
  task automatic applyStimulus(input logic [7:0] c, input logic e, input logic r, input logic clr);
    cnt_in    = c;
    en        = e;
    evt_ready = r;
    ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT out of reset but still in INIT; the next edge captures c.
  task automatic resetDut(input logic [7:0] c);
    cnt_in    = c;
    en        = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_valid", 32'(evt_valid), 32'd0);
    checkOutput("rst_total", total, 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_step_err", 32'(step_err), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cnt_in = 8'h00; en = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;

    // T1: post-reset count value is never read as a burst
    resetDut(8'h37);
    applyStimulus(8'h37, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_pending", 32'(pending), 32'd0);
    checkOutput("t1_valid", 32'(evt_valid), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h37, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_total", total, 32'd0);
    checkOutput("t1_valid_late", 32'(evt_valid), 32'd0);

    // T2: step of 3 drains one event per cycle with ready held high
    resetDut(8'h10);
    applyStimulus(8'h10, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h13, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_pending_first", 32'(pending), 32'd3);
    checkOutput("t2_valid_first", 32'(evt_valid), 32'd1);
    validCycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (evt_valid) validCycles++;
      applyStimulus(8'h13, 1'b1, 1'b1, 1'b0);
    end
    checkOutput("t2_valid_cycles", 32'(validCycles), 32'd3);
    checkOutput("t2_total", total, 32'd3);
    checkOutput("t2_pending_end", 32'(pending), 32'd0);

    // T3: wrap 0xFE -> 0x01 is delta 3; valid holds while ready is low
    resetDut(8'hFE);
    applyStimulus(8'hFE, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_pending_wrap", 32'(pending), 32'd3);
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_pending_hold", 32'(pending), 32'd3);
    checkOutput("t3_valid_hold", 32'(evt_valid), 32'd1);
    checkOutput("t3_total_hold", total, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
    checkOutput("t3_total", total, 32'd3);
    checkOutput("t3_pending_end", 32'(pending), 32'd0);
    checkOutput("t3_valid_end", 32'(evt_valid), 32'd0);

    // T4: saturation on the PW=4 copy, clear, then clear racing a new saturation
    resetDut(8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd20, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_small_pending_sat", 32'(pending_s), 32'd15);
    checkOutput("t4_small_ovf_set", 32'(ovf_s), 32'd1);
    checkOutput("t4_big_pending", 32'(pending), 32'd20);
    checkOutput("t4_big_ovf", 32'(ovf), 32'd0);
    applyStimulus(8'd20, 1'b1, 1'b0, 1'b1);
    checkOutput("t4_small_ovf_clr", 32'(ovf_s), 32'd0);
    checkOutput("t4_small_pending_kept", 32'(pending_s), 32'd15);
    applyStimulus(8'd21, 1'b1, 1'b0, 1'b1);
    checkOutput("t4_small_ovf_set_wins", 32'(ovf_s), 32'd1);
    checkOutput("t4_small_pending_still", 32'(pending_s), 32'd15);
    checkOutput("t4_big_pending_21", 32'(pending), 32'd21);

    // T5: deltas during en=0 are dropped; add and take together cancel
    resetDut(8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_pending_disabled", 32'(pending), 32'd0);
    checkOutput("t5_valid_disabled", 32'(evt_valid), 32'd0);
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_pending_two", 32'(pending), 32'd2);
    applyStimulus(8'h08, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_pending_add_take", 32'(pending), 32'd2);
    checkOutput("t5_total_add_take", total, 32'd1);
    applyStimulus(8'h08, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_pending_drain", 32'(pending), 32'd1);
    checkOutput("t5_total_drain", total, 32'd2);

    // Reset mid-operation drops backlog and total (checked inside resetDut)
    // T6: half-range step 0x80 -> 0x00
    resetDut(8'h80);
    applyStimulus(8'h80, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
`ifdef CNT_EVT_STEP_CHK_EN
    checkOutput("t6_step_err", 32'(step_err), 32'd1);
    checkOutput("t6_pending", 32'(pending), 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("t6_step_err_clr", 32'(step_err), 32'd0);
`else
    checkOutput("t6_step_err", 32'(step_err), 32'd0);
    checkOutput("t6_pending", 32'(pending), 32'd128);
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_pending_plus1", 32'(pending), 32'd129);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
